// File: rtl/max10nios_stream_in_pkg.sv
// Shared register-map and edge-type constants for the max10nios_stream_in input PIO.
package max10nios_stream_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_DATA = 2'd0;
  localparam reg_addr_t ADDR_MASK = 2'd1;
  localparam reg_addr_t ADDR_RSVD = 2'd2;
  localparam reg_addr_t ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/max10nios_stream_in_if.sv
// Avalon-MM slave bus bundle (plus interrupt line) for the max10nios_stream_in PIO.
interface max10nios_stream_in_if;
  import max10nios_stream_pkg::*;

  reg_addr_t   address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/max10nios_stream_in_sync_edge.sv
// Input synchronizer, previous-value register and post-reset arm counter producing
// per-bit edge pulses for the capture register.
module max10nios_sync_edge
  import max10nios_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] det
);

  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] sync [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_sel;
  logic [CW-1:0]    arm_cnt;
  logic             armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      prev <= sync_q;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  assign sync_q = sync[SYNC_STAGES-1];
  assign armed  = (arm_cnt == CW'(ARM_MAX));

  // Until the pipeline has flushed after reset, sync_q/prev differences are reset
  // artefacts rather than real input edges, so detection is held off.
  assign edge_sel = (EDGE_TYPE == EDGE_RISE) ? (sync_q & ~prev) :
                    (EDGE_TYPE == EDGE_FALL) ? (~sync_q & prev) :
                                               (sync_q ^ prev);
  assign det = armed ? edge_sel : '0;

endmodule

// File: rtl/max10nios_stream_in.sv
// Avalon-MM input PIO with sticky edge capture; the mask register and irq exist only
// when MAX10NIOS_STREAM_IN_IRQ_EN is defined (otherwise irq is tied low).
module max10nios_stream_in
  import max10nios_stream_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                    clk,
  input  logic                    reset,
  max10nios_stream_in_if.slave    bus,
  input  logic [WIDTH-1:0]        in_port
);

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             rd;
  logic             unused_wdata;

  assign wr           = bus.chipselect & ~bus.write_n;
  assign rd           = bus.chipselect & ~bus.read_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign clr          = (wr && bus.address == ADDR_EDGE) ? wdata : '0;

  max10nios_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_q  (sync_q),
    .det     (det)
  );

  // A detect arriving in the same cycle as a clear wins, so no edge is ever lost.
  always_ff @(posedge clk) begin
    if (reset) cap <= '0;
    else       cap <= (cap & ~clr) | det;
  end

`ifdef MAX10NIOS_STREAM_IN_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      mask    <= '0;
      bus.irq <= 1'b0;
    end else begin
      if (wr && bus.address == ADDR_MASK) mask <= wdata;
      bus.irq <= |(cap & mask);
    end
  end
`else
  assign bus.irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = 32'(sync_q);
`ifdef MAX10NIOS_STREAM_IN_IRQ_EN
      ADDR_MASK: rd_mux = 32'(mask);
`endif
      ADDR_EDGE: rd_mux = 32'(cap);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)   bus.readdata <= '0;
    else if (rd) bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_max10nios_stream_in.sv
// Scoreboard bench driving three max10nios_stream_in instances (rising, falling, any edge)
// from one shared bus and input vector; honours MAX10NIOS_STREAM_IN_IRQ_EN.
module tb_max10nios_stream_in;
  import max10nios_stream_pkg::*;

  localparam int WIDTH = 8;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  reg_addr_t        address    = '0;
  logic             chipselect = 1'b0;
  logic             read_n     = 1'b1;
  logic             write_n    = 1'b1;
  logic [31:0]      writedata  = '0;
  logic [WIDTH-1:0] in_v       = '0;
  logic             rd_seen    = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] e_r;
    logic [31:0] e_f;
    logic [31:0] e_a;
  } rd_exp_t;

  rd_exp_t sb[$];
  rd_exp_t mon_item;

  always #5 clk = ~clk;

  max10nios_stream_in_if bus_rise ();
  max10nios_stream_in_if bus_fall ();
  max10nios_stream_in_if bus_any ();

  assign bus_rise.address    = address;
  assign bus_rise.chipselect = chipselect;
  assign bus_rise.read_n     = read_n;
  assign bus_rise.write_n    = write_n;
  assign bus_rise.writedata  = writedata;
  assign bus_fall.address    = address;
  assign bus_fall.chipselect = chipselect;
  assign bus_fall.read_n     = read_n;
  assign bus_fall.write_n    = write_n;
  assign bus_fall.writedata  = writedata;
  assign bus_any.address     = address;
  assign bus_any.chipselect  = chipselect;
  assign bus_any.read_n      = read_n;
  assign bus_any.write_n     = write_n;
  assign bus_any.writedata   = writedata;

  max10nios_stream_in #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_RISE)) dut_rise (
    .clk (clk), .reset (reset), .bus (bus_rise), .in_port (in_v)
  );
  max10nios_stream_in #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_FALL)) dut_fall (
    .clk (clk), .reset (reset), .bus (bus_fall), .in_port (in_v)
  );
  max10nios_stream_in #(.WIDTH(WIDTH), .SYNC_STAGES(2), .EDGE_TYPE(EDGE_ANY)) dut_any (
    .clk (clk), .reset (reset), .bus (bus_any), .in_port (in_v)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) tick();
  endtask

  // One bus cycle; a read pushes the per-instance expected readdata onto the scoreboard.
  task automatic applyStimulus(input bit do_rd, input bit do_wr, input reg_addr_t addr,
                               input logic [31:0] wdata, input string tag,
                               input logic [31:0] e_r, input logic [31:0] e_f,
                               input logic [31:0] e_a);
    rd_exp_t item;
    chipselect = 1'b1;
    read_n     = !do_rd;
    write_n    = !do_wr;
    address    = addr;
    writedata  = wdata;
    if (do_rd) begin
      item.tag = tag;
      item.e_r = e_r;
      item.e_f = e_f;
      item.e_a = e_a;
      sb.push_back(item);
    end
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
  endtask

  task automatic rdReg(input reg_addr_t addr, input string tag,
                       input logic [31:0] e_r, input logic [31:0] e_f, input logic [31:0] e_a);
    applyStimulus(1'b1, 1'b0, addr, 32'h0, tag, e_r, e_f, e_a);
  endtask

  task automatic wrReg(input reg_addr_t addr, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, data, "wr", 32'h0, 32'h0, 32'h0);
  endtask

  always @(posedge clk) rd_seen <= chipselect & ~read_n;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_item = sb.pop_front();
        checkOutput({mon_item.tag, "_rise"}, bus_rise.readdata, mon_item.e_r);
        checkOutput({mon_item.tag, "_fall"}, bus_fall.readdata, mon_item.e_f);
        checkOutput({mon_item.tag, "_any"},  bus_any.readdata,  mon_item.e_a);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting");
    reset = 1'b1;
    in_v  = 8'hFF;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(6);
    rdReg(ADDR_EDGE, "held_cap",  32'h00, 32'h00, 32'h00);
    rdReg(ADDR_RSVD, "rsvd",      32'h00, 32'h00, 32'h00);
    rdReg(ADDR_DATA, "held_data", 32'hFF, 32'hFF, 32'hFF);
    checkOutput("held_irq_rise", 32'(bus_rise.irq), 32'd0);
    checkOutput("held_irq_any",  32'(bus_any.irq),  32'd0);
    waitCycles(2);
    checkOutput("rd_hold", bus_rise.readdata, 32'hFF);

    reset = 1'b1;
    in_v  = 8'h00;
    waitCycles(2);
    reset = 1'b0;
    checkOutput("reset_readdata", bus_rise.readdata, 32'h00);
    waitCycles(6);
    rdReg(ADDR_EDGE, "rearm_cap", 32'h00, 32'h00, 32'h00);

    // Input change just after an edge: sync_q after edge 2, capture after edge 3.
    in_v = 8'h05;
    tick();
    rdReg(ADDR_DATA, "lat_e2",  32'h00, 32'h00, 32'h00);
    rdReg(ADDR_DATA, "lat_e3",  32'h05, 32'h05, 32'h05);
    rdReg(ADDR_EDGE, "lat_cap", 32'h05, 32'h00, 32'h05);

`ifdef MAX10NIOS_STREAM_IN_IRQ_EN
    wrReg(ADDR_MASK, 32'hFFFF_FF04);
    checkOutput("irq_mask_wr_rise", 32'(bus_rise.irq), 32'd0);
    tick();
    checkOutput("irq_set_rise", 32'(bus_rise.irq), 32'd1);
    checkOutput("irq_set_fall", 32'(bus_fall.irq), 32'd0);
    checkOutput("irq_set_any",  32'(bus_any.irq),  32'd1);
    rdReg(ADDR_MASK, "mask", 32'h04, 32'h04, 32'h04);
    wrReg(ADDR_EDGE, 32'h04);
    checkOutput("irq_clr_edge_rise", 32'(bus_rise.irq), 32'd1);
    tick();
    checkOutput("irq_clr_rise", 32'(bus_rise.irq), 32'd0);
    checkOutput("irq_clr_any",  32'(bus_any.irq),  32'd0);
    rdReg(ADDR_EDGE, "clr_w1c", 32'h01, 32'h00, 32'h01);
`else
    wrReg(ADDR_MASK, 32'hFF);
    rdReg(ADDR_MASK, "mask_absent", 32'h00, 32'h00, 32'h00);
    tick();
    checkOutput("irq_off_rise", 32'(bus_rise.irq), 32'd0);
    checkOutput("irq_off_any",  32'(bus_any.irq),  32'd0);
    wrReg(ADDR_EDGE, 32'h04);
    rdReg(ADDR_EDGE, "clr_w1c", 32'h01, 32'h00, 32'h01);
    checkOutput("irq_off_cap_rise", 32'(bus_rise.irq), 32'd0);
`endif

    wrReg(ADDR_EDGE, 32'hFF);
    in_v = 8'h04;
    waitCycles(4);
    wrReg(ADDR_EDGE, 32'hFF);
    in_v = 8'h05;
    waitCycles(2);
    wrReg(ADDR_EDGE, 32'h01);
    rdReg(ADDR_EDGE, "set_wins", 32'h01, 32'h00, 32'h01);

    wrReg(ADDR_EDGE, 32'hFF);
    in_v = 8'h85;
    waitCycles(4);
    wrReg(ADDR_EDGE, 32'hFF);
    in_v = 8'h05;
    waitCycles(4);
    rdReg(ADDR_EDGE, "fall80", 32'h00, 32'h80, 32'h80);

    wrReg(ADDR_EDGE, 32'hFF);
    in_v = 8'h0D;
    waitCycles(4);
    rdReg(ADDR_EDGE, "any_rise", 32'h08, 32'h00, 32'h08);
    wrReg(ADDR_EDGE, 32'h08);
    rdReg(ADDR_EDGE, "any_clr",  32'h00, 32'h00, 32'h00);
    in_v = 8'h05;
    waitCycles(4);
    rdReg(ADDR_EDGE, "any_fall", 32'h00, 32'h08, 32'h08);

    applyStimulus(1'b1, 1'b1, ADDR_EDGE, 32'hFF, "rw_pre", 32'h00, 32'h08, 32'h08);
    rdReg(ADDR_EDGE, "rw_post", 32'h00, 32'h00, 32'h00);

    wrReg(ADDR_DATA, 32'hFF);
    wrReg(ADDR_RSVD, 32'hFF);
    rdReg(ADDR_DATA, "data_ro", 32'h05, 32'h05, 32'h05);
    rdReg(ADDR_RSVD, "rsvd_wr", 32'h00, 32'h00, 32'h00);

    waitCycles(2);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
